// File: rtl/rvc_asap_5pl_dma_copy.sv
// Word-copy DMA initiator. Reads a block of 32-bit words from a source range
// and writes them to a destination range through the same request interface
// the core uses towards the memory wrapper. Requests are decoded from state
// only, so Grant never reaches a request output combinationally.
module rvc_asap_5pl_dma_copy #(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 32
) (
   input  logic              Clock,
   input  logic              Rst,
   input  logic              Start,
   input  logic [ADDR_W-1:0] SrcAddr,
   input  logic [ADDR_W-1:0] DstAddr,
   input  logic [LEN_W-1:0]  Length,
   input  logic              Grant,
   input  logic [31:0]       DmaRdData,
   output logic [ADDR_W-1:0] DmaAddr,
   output logic [31:0]       DmaWrData,
   output logic [3:0]        DmaByteEn,
   output logic              DmaWrEn,
   output logic              DmaRdEn,
   output logic              Busy,
   output logic              Done,
   output logic [LEN_W-1:0]  WordCnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_REQ = 3'd1,
      RD_CAP = 3'd2,
      WR_REQ = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       data_q, data_d;
   logic [LEN_W-1:0]  cntInc;

   assign cntInc = cnt_q + LEN_W'(1);

   // State and datapath registers; reset abandons any transfer in flight
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // Next-state and datapath update; Start is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               cnt_d = '0;
               if (Length != '0) begin
                  src_d   = {SrcAddr[ADDR_W-1:2], 2'b00};
                  dst_d   = {DstAddr[ADDR_W-1:2], 2'b00};
                  len_d   = Length;
                  state_d = RD_REQ;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RD_REQ: begin
            if (Grant) begin
               state_d = RD_CAP;
            end
         end
         RD_CAP: begin
            data_d  = DmaRdData;
            src_d   = src_q + ADDR_W'(4);
            state_d = WR_REQ;
         end
         WR_REQ: begin
            if (Grant) begin
               dst_d   = dst_q + ADDR_W'(4);
               cnt_d   = cntInc;
               state_d = (cntInc == len_q) ? DONE : RD_REQ;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore output decode from the current state only
   always_comb begin
      DmaAddr   = '0;
      DmaWrData = '0;
      DmaByteEn = 4'h0;
      DmaWrEn   = 1'b0;
      DmaRdEn   = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state_q)
         RD_REQ: begin
            DmaRdEn = 1'b1;
            DmaAddr = src_q;
            Busy    = 1'b1;
         end
         RD_CAP: begin
            Busy = 1'b1;
         end
         WR_REQ: begin
            DmaWrEn   = 1'b1;
            DmaByteEn = 4'hF;
            DmaAddr   = dst_q;
            DmaWrData = data_q;
            Busy      = 1'b1;
         end
         DONE: begin
            Done = 1'b1;
         end
         default: begin
            Busy = 1'b0;
         end
      endcase
   end

   assign WordCnt = cnt_q;

endmodule

// File: tb/tb_rvc_asap_5pl_dma_copy.sv
// Scoreboard bench for the word-copy DMA. A memory reference model expands
// each launched transfer into expected reads, writes and a Done event; a
// monitor acting as the memory wrapper pops and compares them as the DUT
// presents accepted requests.
module tb_rvc_asap_5pl_dma_copy;

   localparam int LEN_W  = 16;
   localparam int ADDR_W = 32;

   logic              Clock     = 1'b0;
   logic              Rst       = 1'b0;
   logic              Start     = 1'b0;
   logic [ADDR_W-1:0] SrcAddr   = '0;
   logic [ADDR_W-1:0] DstAddr   = '0;
   logic [LEN_W-1:0]  Length    = '0;
   logic              Grant     = 1'b1;
   logic [31:0]       DmaRdData = '0;
   logic [ADDR_W-1:0] DmaAddr;
   logic [31:0]       DmaWrData;
   logic [3:0]        DmaByteEn;
   logic              DmaWrEn;
   logic              DmaRdEn;
   logic              Busy;
   logic              Done;
   logic [LEN_W-1:0]  WordCnt;

   rvc_asap_5pl_dma_copy #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
      .Clock(Clock), .Rst(Rst), .Start(Start), .SrcAddr(SrcAddr),
      .DstAddr(DstAddr), .Length(Length), .Grant(Grant),
      .DmaRdData(DmaRdData), .DmaAddr(DmaAddr), .DmaWrData(DmaWrData),
      .DmaByteEn(DmaByteEn), .DmaWrEn(DmaWrEn), .DmaRdEn(DmaRdEn),
      .Busy(Busy), .Done(Done), .WordCnt(WordCnt)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          idx;
   } wrExp_t;

   typedef struct {
      int startCyc;
      int len;
      int stallBase;
   } doneExp_t;

   logic [31:0] rdQ[$];
   wrExp_t      wrQ[$];
   doneExp_t    doneQ[$];
   logic [31:0] physMem[logic [31:0]];
   logic [31:0] modelMem[logic [31:0]];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stallTotal = 0;
   int startCyc = 0;
   int lowLo[$];
   int lowHi[$];
   bit grantRandom = 1'b0;

   // 100 MHz-style free-running clock
   always #5 Clock = ~Clock;

   // Cycle counter used to time Done against the launching Start
   always @(posedge Clock) cyc <= cyc + 1;

   // Hard stop in case the design wedges the whole run
   initial begin
      #600000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Untouched memory returns an address-derived pattern
   function automatic logic [31:0] fillWord(input logic [31:0] a);
      return a ^ 32'h5EED_0000 ^ {a[15:0], 16'h0};
   endfunction

   function automatic logic [31:0] physRead(input logic [31:0] a);
      return physMem.exists(a) ? physMem[a] : fillWord(a);
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      return modelMem.exists(a) ? modelMem[a] : fillWord(a);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic reportFail(input string name, input logic [31:0] actual);
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=%h required=none", name, actual);
   endtask

   task automatic checkZeroOutputs(input string tag);
      checkOutput({tag, "_addr"}, DmaAddr, 32'h0);
      checkOutput({tag, "_wdata"}, DmaWrData, 32'h0);
      checkOutput({tag, "_ctrl"}, 32'({Busy, Done, DmaRdEn, DmaWrEn, DmaByteEn}), 32'h0);
      checkOutput({tag, "_wordcnt"}, 32'(WordCnt), 32'h0);
   endtask

   task automatic flushExpect();
      rdQ.delete();
      wrQ.delete();
      doneQ.delete();
      modelMem = physMem;
   endtask

   // Grant driver: forced-low windows relative to the last Start, else
   // either always granted or randomly granted three times out of four
   always begin : grantDrv
      int  rel;
      bit  low;
      @(posedge Clock);
      #3;
      rel = cyc - startCyc;
      low = 1'b0;
      foreach (lowLo[i]) begin
         if (rel >= lowLo[i] && rel <= lowHi[i]) low = 1'b1;
      end
      Grant = low ? 1'b0 : (grantRandom ? ($urandom_range(0, 3) != 0) : 1'b1);
   end

   // Launch a transfer and expand it through the memory model into the
   // expected read addresses, write beats and Done event
   task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                input int len);
      logic [31:0] s;
      logic [31:0] d;
      logic [31:0] v;
      @(posedge Clock);
      #2;
      SrcAddr  = src;
      DstAddr  = dst;
      Length   = LEN_W'(len);
      Start    = 1'b1;
      startCyc = cyc;
      s = {src[31:2], 2'b00};
      d = {dst[31:2], 2'b00};
      for (int i = 0; i < len; i++) begin
         v = modelRead(s + 32'(4 * i));
         rdQ.push_back(s + 32'(4 * i));
         wrQ.push_back('{addr: d + 32'(4 * i), data: v, idx: i});
         modelMem[d + 32'(4 * i)] = v;
      end
      doneQ.push_back('{startCyc: cyc, len: len, stallBase: stallTotal});
      @(posedge Clock);
      #2;
      Start   = 1'b0;
      SrcAddr = $urandom();
      DstAddr = $urandom();
      Length  = LEN_W'($urandom());
   endtask

   // Start pulse that the DUT must ignore; nothing is expected from it
   task automatic pokeStart(input logic [31:0] src, input logic [31:0] dst,
                            input int len);
      SrcAddr = src;
      DstAddr = dst;
      Length  = LEN_W'(len);
      Start   = 1'b1;
      @(posedge Clock);
      #2;
      Start = 1'b0;
   endtask

   task automatic waitCycle(input int target);
      while (cyc < target) begin
         @(posedge Clock);
         #2;
      end
   endtask

   task automatic waitDone(input int budget, input string name);
      int n;
      n = 0;
      while (doneQ.size() != 0 && n < budget) begin
         @(posedge Clock);
         n++;
      end
      checkOutput({name, "_done_seen"}, 32'(doneQ.size()), 32'h0);
      if (doneQ.size() != 0) flushExpect();
      repeat (3) @(posedge Clock);
   endtask

   // Monitor and memory wrapper: checks every cycle on the falling edge and
   // returns read data one cycle after each accepted read
   initial begin : monitor
      logic        prevStall;
      logic        pRd, pWr;
      logic [31:0] pAddr, pData;
      logic [3:0]  pBe;
      logic        rdNext;
      logic [31:0] rdVal;
      wrExp_t      w;
      doneExp_t    e;
      logic [31:0] a;
      prevStall = 1'b0;
      pRd = 1'b0; pWr = 1'b0; pAddr = '0; pData = '0; pBe = '0;
      rdVal = '0;
      forever begin
         @(negedge Clock);
         rdNext = 1'b0;
         if (!Rst) begin
            checkZeroOutputs("reset");
            prevStall = 1'b0;
         end else begin
            checkOutput("rd_wr_exclusive", 32'(DmaRdEn & DmaWrEn), 32'h0);
            checkOutput("byte_en", 32'(DmaByteEn), DmaWrEn ? 32'hF : 32'h0);
            checkOutput("addr_align", 32'(DmaAddr[1:0]), 32'h0);
            checkOutput("busy_and_done", 32'(Busy & Done), 32'h0);
            if (DmaRdEn || DmaWrEn) checkOutput("req_busy", 32'(Busy), 32'h1);
            if (prevStall) begin
               checkOutput("stall_rden", 32'(DmaRdEn), 32'(pRd));
               checkOutput("stall_wren", 32'(DmaWrEn), 32'(pWr));
               checkOutput("stall_addr", DmaAddr, pAddr);
               checkOutput("stall_wdata", DmaWrData, pData);
               checkOutput("stall_be", 32'(DmaByteEn), 32'(pBe));
            end
            if (DmaRdEn && Grant) begin
               if (rdQ.size() == 0) begin
                  reportFail("unexpected_read", DmaAddr);
               end else begin
                  a = rdQ.pop_front();
                  checkOutput("read_addr", DmaAddr, a);
               end
               rdNext = 1'b1;
               rdVal  = physRead(DmaAddr);
            end
            if (DmaWrEn && Grant) begin
               if (wrQ.size() == 0) begin
                  reportFail("unexpected_write", DmaAddr);
               end else begin
                  w = wrQ.pop_front();
                  checkOutput("write_addr", DmaAddr, w.addr);
                  checkOutput("write_data", DmaWrData, w.data);
                  checkOutput("write_wordcnt", 32'(WordCnt), 32'(w.idx));
               end
               physMem[DmaAddr] = DmaWrData;
            end
            if ((DmaRdEn || DmaWrEn) && !Grant) begin
               stallTotal++;
               prevStall = 1'b1;
               pRd = DmaRdEn; pWr = DmaWrEn; pAddr = DmaAddr;
               pData = DmaWrData; pBe = DmaByteEn;
            end else begin
               prevStall = 1'b0;
            end
            if (Done) begin
               if (doneQ.size() == 0) begin
                  reportFail("unexpected_done", 32'(WordCnt));
               end else begin
                  e = doneQ.pop_front();
                  checkOutput("done_cycle", 32'(cyc),
                              32'(e.startCyc + 3 * e.len + 1 + (stallTotal - e.stallBase)));
                  checkOutput("done_wordcnt", 32'(WordCnt), 32'(e.len));
                  checkOutput("done_reads_left", 32'(rdQ.size()), 32'h0);
                  checkOutput("done_writes_left", 32'(wrQ.size()), 32'h0);
               end
            end
         end
         @(posedge Clock);
         #1;
         DmaRdData = rdNext ? rdVal : $urandom();
      end
   end

   // Directed scenarios followed by randomized overlapping copies
   initial begin : stimulus
      logic [31:0] src;
      logic [31:0] dst;
      int          len;
      int          base;
      repeat (3) @(posedge Clock);
      #2;
      checkZeroOutputs("por");
      Rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         physMem[32'h1000 + 32'(4 * i)]  = 32'hA0A0_0000 + 32'(i);
         modelMem[32'h1000 + 32'(4 * i)] = 32'hA0A0_0000 + 32'(i);
      end

      $display("[TB] basic copy");
      applyStimulus(32'h1000, 32'h2000, 4);
      waitDone(60, "basic");
      checkOutput("wordcnt_hold", 32'(WordCnt), 32'h4);
      for (int i = 0; i < 4; i++)
         checkOutput("basic_mem", physRead(32'h2000 + 32'(4 * i)), 32'hA0A0_0000 + 32'(i));

      $display("[TB] grant stall");
      lowLo = '{1, 11};
      lowHi = '{5, 13};
      applyStimulus(32'h1000, 32'h2100, 2);
      waitDone(60, "stall");
      lowLo.delete();
      lowHi.delete();

      $display("[TB] unaligned and zero length");
      applyStimulus(32'h1003, 32'h2201, 1);
      waitDone(30, "unaligned");
      applyStimulus(32'h1000, 32'h2300, 0);
      waitDone(10, "zero_len");
      checkOutput("zero_len_wordcnt", 32'(WordCnt), 32'h0);

      $display("[TB] address wrap");
      applyStimulus(32'hFFFF_FFF8, 32'h3000, 3);
      waitDone(40, "wrap");

      $display("[TB] start while busy");
      applyStimulus(32'h1000, 32'h2400, 3);
      base = startCyc;
      waitCycle(base + 4);
      pokeStart(32'h5000, 32'h6000, 5);
      waitCycle(base + 10);
      checkOutput("poke_in_done", 32'(Done), 32'h1);
      pokeStart(32'h5100, 32'h6100, 7);
      waitDone(40, "busy_start");
      repeat (10) @(posedge Clock);

      $display("[TB] reset mid-transfer");
      applyStimulus(32'h1000, 32'h2500, 3);
      base = startCyc;
      waitCycle(base + 6);
      checkOutput("pre_reset_wren", 32'(DmaWrEn), 32'h1);
      Rst = 1'b0;
      #1;
      checkZeroOutputs("mid_reset");
      flushExpect();
      repeat (3) @(posedge Clock);
      #2;
      Rst = 1'b1;
      repeat (3) @(posedge Clock);
      applyStimulus(32'h1004, 32'h2600, 3);
      waitDone(40, "post_reset");

      $display("[TB] randomized copies");
      grantRandom = 1'b1;
      for (int t = 0; t < 12; t++) begin
         src = 32'h4000 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
         dst = 32'h4000 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
         len = $urandom_range(0, 10);
         applyStimulus(src, dst, len);
         waitDone(40 * len + 40, "random");
      end
      grantRandom = 1'b0;
      repeat (5) @(posedge Clock);

      foreach (physMem[a]) checkOutput("final_mem", physMem[a], modelRead(a));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rvc_asap_5pl_dma_copy.md
Name: rvc_asap_5pl_dma_copy

Overview:
- Memory-side initiator: copies a block of 32-bit words from a source to a destination address range.
- Issues the same request signals the core drives into the memory wrapper: address, write data, byte enable, write enable and read-select. Read data returns one cycle after the request.
- Sits beside the core. A top-level arbiter muxes its requests into the memory wrapper when Grant is high, so the DMA can move data into D_MEM, CR_MEM or the VGA region without the core running loads and stores.

Parameters:
LEN_W  16  width of the word-count register (maximum transfer 2^LEN_W-1 words)
ADDR_W  32  address width of the source, destination and request address

Ports:
Clock  input  1  core clock
Rst  input  1  asynchronous, active-low reset
Start  input  1  single-cycle pulse that launches a transfer; sampled only in IDLE
SrcAddr  input  ADDR_W  source byte address; bits[1:0] ignored
DstAddr  input  ADDR_W  destination byte address; bits[1:0] ignored
Length  input  LEN_W  number of words to copy
Grant  input  1  arbiter grant; a request is accepted only in a cycle where Grant=1
DmaRdData  input  32  memory read data, valid the cycle after an accepted read
DmaAddr  output  ADDR_W  request address (word aligned, bits[1:0]=0)
DmaWrData  output  32  write data
DmaByteEn  output  4  byte enable; always 4'b1111 while a write is requested, else 0
DmaWrEn  output  1  write request
DmaRdEn  output  1  read request (same role as the SelDMemWb select)
Busy  output  1  high from the cycle after Start is accepted until Done
Done  output  1  one-cycle pulse when a transfer completes
WordCnt  output  LEN_W  number of words written so far in the current transfer

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE; all outputs 0; internal source/destination pointers, word counter and data register cleared. A reset in the middle of a transfer abandons it, with no Done and no further requests.
- States: IDLE, RD_REQ, RD_CAP, WR_REQ, DONE.
- IDLE:
  - Start=1 and Length!=0: latch {SrcAddr[31:2],2'b00}, {DstAddr[31:2],2'b00} and Length; clear WordCnt; go to RD_REQ.
  - Start=1 and Length=0: go to DONE directly; no memory request is issued.
  - Start=0: stay in IDLE.
- RD_REQ: DmaRdEn=1, DmaAddr=src pointer, DmaWrEn=0.
  - Grant=1: request accepted; go to RD_CAP.
  - Grant=0: hold the request with identical outputs and stay.
- RD_CAP:
  - All requests deasserted.
  - Capture DmaRdData into the data register; increment src pointer by 4; go to WR_REQ.
  - Read latency is exactly 1 cycle, independent of Grant.
- WR_REQ: DmaWrEn=1, DmaByteEn=4'hF, DmaAddr=dst pointer, DmaWrData=data register.
  - Grant=0: hold the request.
  - Grant=1: write accepted. Increment dst pointer by 4 and WordCnt by 1.
  - If WordCnt+1==Length, go to DONE; otherwise go to RD_REQ.
- DONE: Done=1 and Busy=0 for one cycle; go to IDLE.
- Busy=1 in RD_REQ, RD_CAP and WR_REQ; Busy=0 in IDLE and DONE.
- Minimum throughput: 3 cycles per word with Grant held high.
- Requests are Moore outputs, decoded from state only; no combinational path from Grant to any request output.
- Start while not in IDLE is ignored, including Start asserted in the DONE cycle.
- Pointers increment modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- Overlapping source and destination ranges are not detected. The copy is strictly ascending, word by word.
- WordCnt holds its final value after DONE until the next accepted Start clears it.
- DmaRdEn and DmaWrEn are never high in the same cycle.

Test Plan:
- Basic copy: preload 0x1000..0x100C with A0,A1,A2,A3; Grant=1; Start with Src=0x1000, Dst=0x2000, Len=4 -> writes to 0x2000,0x2004,0x2008,0x200C with data A0..A3. Done pulses in cycle 13 after Start. WordCnt=4.
- Grant stall: repeat with Len=2 and Grant forced low for 5 cycles during the first RD_REQ and 3 cycles during the second WR_REQ -> request outputs stable throughout each stall. Same data is written. Done arrives 8 cycles later than the Grant=1 run.
- Unaligned and zero length: Src=0x1003, Dst=0x2001, Len=1 -> read at 0x1000, write at 0x2000. Len=0 -> no DmaRdEn/DmaWrEn ever; Done pulses 1 cycle after Start.
- Address wrap: Src=0xFFFF_FFF8, Len=3 -> reads at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Start while busy: pulse Start with different arguments mid-transfer and in the DONE cycle -> ignored; the original transfer completes unchanged.
- Reset mid-transfer: drop Rst during WR_REQ of word 2 -> all outputs 0 immediately, state IDLE, no Done. A new Start after release behaves as a fresh transfer.
